int_queue_reader: RTL and testbench



---
 rtl/int_queue_reader.sv | 133 +++++++++++++
 tb/tb_int_queue_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int_queue_reader.sv
// Consumer side of the integer instruction queue: pops the FIFO, hides its one-cycle
// read latency behind a 2-entry buffer, issues over valid/ready. Stats: INTQ_READER_STATS_EN.
module int_queue_reader #(
  parameter int BIT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_in,
  input  logic               reset_issue,
  input  logic               empty_fifo,
  output logic               rd_enable,
  input  logic [BIT_LEN-1:0] rd_data,
  input  logic               flush,
  output logic               out_valid,
  output logic [BIT_LEN-1:0] out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   issued_count,
  output logic [CNT_W-1:0]   stall_count
);

  // state     | meaning
  // OCC_EMPTY | no word buffered
  // OCC_ONE   | head word in buf0
  // OCC_FULL  | head in buf0, next word in buf1
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [1:0]         occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic               discard_q, discard_d;
  logic [BIT_LEN-1:0] buf0_q, buf0_d;
  logic [BIT_LEN-1:0] buf1_q, buf1_d;

  logic       pop;
  logic       capture;
  logic [2:0] committed;

  assign out_valid = (occ_q != OCC_EMPTY) & ~flush;
  assign out_data  = buf0_q;
  assign pop       = out_valid & out_ready;
  assign capture   = inflight_q & ~discard_q & ~flush;

  // Words already owned by this block after this cycle's pop; a new pop may only
  // be requested while that leaves room for the returning word.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_enable = ~reset_issue & ~empty_fifo & ~flush & (committed < 3'd2);

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd_enable;
    discard_d  = flush & inflight_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (occ_q == OCC_EMPTY) begin
            buf0_d = rd_data;
          end else begin
            buf1_d = rd_data;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          buf0_d = buf1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == OCC_FULL) begin
            buf0_d = buf1_q;
            buf1_d = rd_data;
          end else begin
            buf0_d = rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_issue) begin
    if (reset_issue) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef INTQ_READER_STATS_EN
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (pop && (issued_q != {CNT_W{1'b1}})) begin
      issued_d = issued_q + 1'b1;
    end
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_issue) begin
    if (reset_issue) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_count = issued_q;
  assign stall_count  = stall_q;
`else
  assign issued_count = '0;
  assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_int_queue_reader.sv
// Scoreboard bench for int_queue_reader: a queue-level FIFO model feeds the DUT and
// a negedge monitor checks every cycle against the outstanding-word list.
module tb_int_queue_reader;
  localparam int BIT_LEN = 4;
  localparam int CNT_W   = 16;

  logic               clk_in      = 1'b0;
  logic               reset_issue = 1'b1;
  logic               empty_fifo  = 1'b1;
  logic               flush       = 1'b0;
  logic               out_ready   = 1'b0;
  logic [BIT_LEN-1:0] rd_data     = '0;
  logic               rd_enable;
  logic               out_valid;
  logic [BIT_LEN-1:0] out_data;
  logic [CNT_W-1:0]   issued_count;
  logic [CNT_W-1:0]   stall_count;

  int_queue_reader #(.BIT_LEN(BIT_LEN), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .reset_issue(reset_issue), .empty_fifo(empty_fifo),
    .rd_enable(rd_enable), .rd_data(rd_data), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .issued_count(issued_count), .stall_count(stall_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [BIT_LEN-1:0] data;
    int                 cyc;
  } ent_t;

  ent_t               exp_q[$];
  logic [BIT_LEN-1:0] fifo_q[$];
  logic [BIT_LEN-1:0] pend_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, n_issued = 0, n_rd = 0;
  int m_iss = 0, m_stl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Synchronous FIFO model: registered read data and registered empty flag.
  always @(posedge clk_in) begin
    if (rd_enable && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
    foreach (pend_q[i]) fifo_q.push_back(pend_q[i]);
    pend_q.delete();
    empty_fifo <= (fifo_q.size() == 0);
  end

  // Monitor: a word popped in cycle N is issuable from cycle N+2, in pop order;
  // at most two words may be outstanding; flush drops everything outstanding.
  always @(negedge clk_in) begin : mon
    bit ev, er, pe;
    cyc++;
    if (reset_issue) begin
      exp_q.delete();
      m_iss = 0;
      m_stl = 0;
    end else begin
      ev = !flush && exp_q.size() > 0 && (exp_q[0].cyc + 2 <= cyc);
      pe = ev && out_ready;
      er = !empty_fifo && !flush && ((exp_q.size() - (pe ? 1 : 0)) < 2);
      chk("out_valid", out_valid, ev);
      if (ev) chk("out_data", out_data, exp_q[0].data);
      chk("rd_enable", rd_enable, er);
`ifdef INTQ_READER_STATS_EN
      chk("issued_count", issued_count, m_iss);
      chk("stall_count", stall_count, m_stl);
`else
      chk("issued_count_zero", issued_count, 0);
      chk("stall_count_zero", stall_count, 0);
`endif
      if (pe) begin
        void'(exp_q.pop_front());
        n_issued++;
        m_iss++;
      end
      if (ev && !out_ready) m_stl++;
      if (flush) exp_q.delete();
      if (rd_enable) begin
        n_rd++;
        if (fifo_q.size() > 0) exp_q.push_back('{fifo_q[0], cyc});
        else chk("pop_on_empty", 1, 0);
      end
    end
  end

  int base, base_rd;

  initial begin
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_rd_enable", rd_enable, 0);
    step(2);
    reset_issue = 1'b0;
    step(3);
    chk("idle_rd_enable", rd_enable, 0);

    // streaming 1..4 with ready held high
    out_ready = 1'b1;
    base = n_issued;
    for (int i = 1; i <= 4; i++) pend_q.push_back(BIT_LEN'(i));
    step(10);
    chk("stream_count", n_issued - base, 4);

    // backpressure: only two words may be taken
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) pend_q.push_back(BIT_LEN'(i));
    step(8);
    chk("bp_rd_enable", rd_enable, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 1);
    base = n_issued;
    out_ready = 1'b1;
    step(8);
    chk("bp_drain", n_issued - base, 3);

    // flush with 5 buffered and 6 in flight
    out_ready = 1'b0;
    pend_q.push_back(4'd5);
    pend_q.push_back(4'd6);
    for (int k = 0; k < 20 && exp_q.size() != 2; k++) step(1);
    chk("flush_setup", exp_q.size(), 2);
    chk("flush_head", out_data, 5);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("post_flush_valid", out_valid, 0);
    base = n_issued;
    out_ready = 1'b1;
    pend_q.push_back(4'd7);
    step(6);
    chk("post_flush_issue", n_issued - base, 1);

    // single word then empty
    base = n_issued;
    base_rd = n_rd;
    pend_q.push_back(4'd9);
    step(8);
    chk("single_rd_pulse", n_rd - base_rd, 1);
    chk("single_issue", n_issued - base, 1);
    chk("empty_rd_enable", rd_enable, 0);

    // randomized traffic with backpressure and occasional flush
    repeat (1500) begin
      if (fifo_q.size() + pend_q.size() < 6 && $urandom_range(0, 2) != 0)
        pend_q.push_back(BIT_LEN'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      step(1);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && (exp_q.size() + fifo_q.size() + pend_q.size()) != 0; k++) step(1);
    chk("drain_timeout", exp_q.size() + fifo_q.size() + pend_q.size(), 0);

    // asynchronous reset mid-stream with the buffer full
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) pend_q.push_back(BIT_LEN'(i));
    step(8);
    chk("pre_reset_valid", out_valid, 1);
    @(posedge clk_in);
    #3;
    reset_issue = 1'b1;
    fifo_q.delete();
    pend_q.delete();
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_data", out_data, 0);
    chk("async_reset_rd_enable", rd_enable, 0);
    step(2);
    reset_issue = 1'b0;
    out_ready = 1'b1;
    step(4);
    chk("post_reset_rd_enable", rd_enable, 0);
    chk("post_reset_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
